char_packer: RTL and testbench

Upstream stage of the vowel-filter datapath. Accepts an ASCII character stream one byte per cycle over a valid/ready handshake and packs it into 8-lane words. Lane `d1` holds the first character received and `d8` the last. Each packed word is presented to the vowel-remover's inputs `i1..i8` through a valid/ready output register. Partial words are closed by `in_last` and filled with a pad character.

---
 rtl/char_packer.sv | 194 +++++++++++++++++++
 tb/tb_char_packer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/char_packer.sv
// char_packer -- upstream stage of the vowel-filter datapath.
//
// Packs a byte-per-cycle ASCII stream into 8-lane words. Lane d1 holds the
// first character of a word and d8 the last. A word closes on its 8th stored
// byte or on in_last. Lanes not written when a word closes early are filled
// with PAD. Closed words go to a valid/ready output register that feeds the
// vowel remover's i1..i8.
//
// Storage is two stages:
//   _p0 : assembly buffer (asm_buf_p0, cnt_p0, asm_full_p0)
//   _p1 : output register (out_d_p1, out_cnt_p1, vld_p1)
//
// Parameters:
//   PAD        fill byte for unwritten lanes (default 8'h20)
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_data[7:0]        input character
//   in_valid, in_last   input handshake valid / word-close marker
//   in_ready            byte accepted this cycle (= !asm_full)
//   d1..d8[7:0]         packed word lanes
//   out_count[3:0]      real characters in the word (1..8)
//   out_valid           d1..d8 / out_count valid
//   out_ready           consumer takes the word
//   err_cnt[7:0]        rejected-character count, saturating
//
// Build option:
//   CHAR_CHECK_EN  when defined, only letters are stored (lowercase is
//                  converted to uppercase); other bytes are dropped and
//                  counted in err_cnt. When undefined, every byte is stored
//                  verbatim and err_cnt is tied to zero.

module char_packer #(
    parameter logic [7:0] PAD = 8'h20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] d1,
    output logic [7:0] d2,
    output logic [7:0] d3,
    output logic [7:0] d4,
    output logic [7:0] d5,
    output logic [7:0] d6,
    output logic [7:0] d7,
    output logic [7:0] d8,
    output logic [3:0] out_count,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] err_cnt
);

`ifdef CHAR_CHECK_EN
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction
`endif

    logic [7:0] asm_buf_p0 [8];
    logic [3:0] cnt_p0;
    logic       asm_full_p0;

    logic [7:0] out_d_p1 [8];
    logic [3:0] out_cnt_p1;
    logic       vld_p1;

    logic       accept;
    logic       consume;
    logic       store_ok;
    logic [7:0] store_byte;
    logic [3:0] cnt_nxt;
    logic       close;
    logic       direct;
    logic       hold;
    logic [7:0] word_nxt [8];

    assign in_ready = !asm_full_p0;
    assign accept   = in_valid && in_ready;
    assign consume  = vld_p1 && out_ready;

    // Character classification ahead of storage.
    always_comb begin
        store_ok   = 1'b1;
        store_byte = in_data;
`ifdef CHAR_CHECK_EN
        if (in_data >= 8'h41 && in_data <= 8'h5A) begin
            store_byte = in_data;
        end else if (in_data >= 8'h61 && in_data <= 8'h7A) begin
            store_byte = in_data - 8'h20;
        end else begin
            store_ok = 1'b0;
        end
`endif
    end

    assign cnt_nxt = cnt_p0 + {3'b000, store_ok};

    // A rejected byte can still close a word, but only one that has content.
    assign close = accept && (store_ok ? ((cnt_nxt == 4'd8) || in_last)
                                       : (in_last && (cnt_p0 != 4'd0)));
    assign direct = close && (!vld_p1 || consume);
    assign hold   = close && !direct;

    // Closed word: stored lanes, the incoming byte at lane cnt, PAD above.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < cnt_p0) begin
                word_nxt[i] = asm_buf_p0[i];
            end else if (store_ok && (4'(i) == cnt_p0)) begin
                word_nxt[i] = store_byte;
            end else begin
                word_nxt[i] = PAD;
            end
        end
    end

    // ---- stage p0: assembly buffer data (no reset; qualified by cnt_p0) ----
    always_ff @(posedge clk) begin
        if (!asm_full_p0) begin
            if (hold) begin
                asm_buf_p0 <= word_nxt;
            end else if (accept && store_ok && !close) begin
                asm_buf_p0[cnt_p0[2:0]] <= store_byte;
            end
        end
    end

    // ---- stage p0 -> p1: control and output register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_p0      <= 4'd0;
            asm_full_p0 <= 1'b0;
            vld_p1      <= 1'b0;
            out_cnt_p1  <= 4'd0;
            for (int i = 0; i < 8; i++) begin
                out_d_p1[i] <= 8'h00;
            end
        end else if (asm_full_p0) begin
            // Held word drains into the output register on the consume edge.
            if (consume) begin
                out_d_p1    <= asm_buf_p0;
                out_cnt_p1  <= cnt_p0;
                asm_full_p0 <= 1'b0;
                cnt_p0      <= 4'd0;
            end
        end else if (direct) begin
            out_d_p1   <= word_nxt;
            out_cnt_p1 <= cnt_nxt;
            vld_p1     <= 1'b1;
            cnt_p0     <= 4'd0;
        end else if (hold) begin
            cnt_p0      <= cnt_nxt;
            asm_full_p0 <= 1'b1;
        end else begin
            if (accept && store_ok) begin
                cnt_p0 <= cnt_nxt;
            end
            if (consume) begin
                vld_p1 <= 1'b0;
            end
        end
    end

`ifdef CHAR_CHECK_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= 8'd0;
        end else if (accept && !store_ok) begin
            err_cnt_q <= sat_inc8(err_cnt_q);
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'd0;
`endif

    assign d1        = out_d_p1[0];
    assign d2        = out_d_p1[1];
    assign d3        = out_d_p1[2];
    assign d4        = out_d_p1[3];
    assign d5        = out_d_p1[4];
    assign d6        = out_d_p1[5];
    assign d7        = out_d_p1[6];
    assign d8        = out_d_p1[7];
    assign out_count = out_cnt_p1;
    assign out_valid = vld_p1;

endmodule

// File: tb/tb_char_packer.sv
// Directed bench for char_packer: reset state, full word, early close,
// back-pressure with a held word, same-edge transfer streaming, reset
// mid-word, and character classification when CHAR_CHECK_EN is defined.

module tb_char_packer;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [7:0] d1, d2, d3, d4, d5, d6, d7, d8;
    logic [3:0] out_count;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;

    char_packer #(.PAD(8'h20)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .d4        (d4),
        .d5        (d5),
        .d6        (d6),
        .d7        (d7),
        .d8        (d8),
        .out_count (out_count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] word();
        return {d1, d2, d3, d4, d5, d6, d7, d8};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one byte from a falling edge, wait (bounded) for in_ready,
    // return #1 after the accepting rising edge.
    task automatic send(input logic [7:0] b, input logic l);
        int guard;
        guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        in_last  = l;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) chk("send_timeout_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] exp_w;

        rst       = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_word", word(), 64'd0);
        chk("rst_out_count", {60'd0, out_count}, 64'd0);
        chk("rst_err_cnt", {56'd0, err_cnt}, 64'd0);

        // Full word SRINIVAS with out_ready high
        out_ready = 1'b1;
        send(8'h53, 1'b0); send(8'h52, 1'b0); send(8'h49, 1'b0); send(8'h4E, 1'b0);
        send(8'h49, 1'b0); send(8'h56, 1'b0); send(8'h41, 1'b0);
        chk("full_not_yet_valid", {63'd0, out_valid}, 64'd0);
        send(8'h53, 1'b0);
        chk("full_out_valid", {63'd0, out_valid}, 64'd1);
        chk("full_word", word(), 64'h5352494E_49564153);
        chk("full_count", {60'd0, out_count}, 64'd8);
        tick();
        chk("full_consumed", {63'd0, out_valid}, 64'd0);

        // Early close CAT
        send(8'h43, 1'b0); send(8'h41, 1'b0); send(8'h54, 1'b1);
        chk("early_out_valid", {63'd0, out_valid}, 64'd1);
        chk("early_word", word(), 64'h434154_2020202020);
        chk("early_count", {60'd0, out_count}, 64'd3);
        tick();
        chk("early_consumed", {63'd0, out_valid}, 64'd0);

        // Back-pressure: 16 bytes A..P with out_ready low
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 15; i++) send(8'(8'h41 + i), 1'b0);
        chk("bp_ready_before_16", {63'd0, in_ready}, 64'd1);
        send(8'h50, 1'b0);
        chk("bp_ready_fell", {63'd0, in_ready}, 64'd0);
        chk("bp_word1", word(), 64'h41424344_45464748);
        // 17th byte offered but blocked; output must stay stable
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h51;
        in_last  = 1'b0;
        tick(); tick(); tick();
        chk("bp_still_blocked", {63'd0, in_ready}, 64'd0);
        chk("bp_word1_stable", word(), 64'h41424344_45464748);
        chk("bp_valid_stable", {63'd0, out_valid}, 64'd1);
        @(negedge clk);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_ready_rose", {63'd0, in_ready}, 64'd1);
        chk("bp_word2", word(), 64'h494A4B4C_4D4E4F50);
        chk("bp_word2_count", {60'd0, out_count}, 64'd8);
        chk("bp_word2_valid", {63'd0, out_valid}, 64'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_word2_held", word(), 64'h494A4B4C_4D4E4F50);
        send(8'h52, 1'b1);
        chk("bp_held_short_word", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        out_ready = 1'b1;
        tick();
        chk("bp_word3", word(), 64'h5152_202020202020);
        chk("bp_word3_count", {60'd0, out_count}, 64'd2);
        chk("bp_word3_ready", {63'd0, in_ready}, 64'd1);
        tick();
        chk("bp_drained", {63'd0, out_valid}, 64'd0);

        // Same-edge transfer: 24 continuous bytes A..X, out_ready high
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'(8'h41 + i);
            in_last  = 1'b0;
            tick();
            chk("stream_in_ready", {63'd0, in_ready}, 64'd1);
            if (i % 8 == 7) begin
                exp_w = 64'd0;
                for (int j = 0; j < 8; j++) exp_w = {exp_w[55:0], 8'(8'h41 + i - 7 + j)};
                chk("stream_valid", {63'd0, out_valid}, 64'd1);
                chk("stream_word", word(), exp_w);
            end
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drained", {63'd0, out_valid}, 64'd0);

        // Reset mid-word with a pending output word
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 13; i++) send(8'h5A, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rstmid_in_ready", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;
        send(8'h52, 1'b0); send(8'h4F, 1'b0); send(8'h53, 1'b0); send(8'h45, 1'b0);
        send(8'h42, 1'b0); send(8'h55, 1'b0); send(8'h44, 1'b0); send(8'h53, 1'b0);
        chk("rstmid_word", word(), 64'h524F5345_42554453);
        chk("rstmid_count", {60'd0, out_count}, 64'd8);
        chk("rstmid_err", {56'd0, err_cnt}, 64'd0);
        tick();

        // Classification: a, '1', B(last)
        send(8'h61, 1'b0); send(8'h31, 1'b0); send(8'h42, 1'b1);
        chk("class_valid", {63'd0, out_valid}, 64'd1);
`ifdef CHAR_CHECK_EN
        chk("class_word", word(), 64'h4142_202020202020);
        chk("class_count", {60'd0, out_count}, 64'd2);
        chk("class_err", {56'd0, err_cnt}, 64'd1);
        tick();
        // Rejected byte with in_last on an empty word only bumps err_cnt
        send(8'h31, 1'b1);
        chk("class_empty_last_valid", {63'd0, out_valid}, 64'd0);
        chk("class_empty_last_err", {56'd0, err_cnt}, 64'd2);
`else
        chk("class_word", word(), 64'h613142_2020202020);
        chk("class_count", {60'd0, out_count}, 64'd3);
        chk("class_err", {56'd0, err_cnt}, 64'd0);
`endif
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
